data_mem_access_sequencer: RTL

- Sequences 8-bit data memory accesses for the load/store memory stage.
- Accepts one byte, halfword or word load/store request per transaction and splits it into consecutive single-byte accesses on the byte-wide data memory port.
- Assembles load data (little-endian, optional sign extension) and reports completion with a one-cycle done pulse.
- Sits between the memory-stage datapath and the byte-wide data memory.

---
 rtl/data_mem_access_sequencer_if.sv | 35 +++
 rtl/data_mem_access_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/data_mem_access_sequencer_if.sv
// Request and byte-memory bus bundle for the
// data memory access sequencer.
interface data_mem_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_in;
  logic              we_in;
  logic [1:0]        size_in;
  logic              sign_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wd_in;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  logic [DATA_W-1:0] rd_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_we_out;
  logic [7:0]        mem_wd_out;
  logic [7:0]        mem_rd_in;

  modport master (
    output req_in, we_in, size_in, sign_in,
    output addr_in, wd_in, mem_rd_in,
    input  busy_out, done_out, err_out, rd_out,
    input  mem_addr_out, mem_we_out, mem_wd_out
  );

  modport slave (
    input  req_in, we_in, size_in, sign_in,
    input  addr_in, wd_in, mem_rd_in,
    output busy_out, done_out, err_out, rd_out,
    output mem_addr_out, mem_we_out, mem_wd_out
  );
endinterface

// File: rtl/data_mem_access_sequencer.sv
// Splits byte/half/word load-store requests into
// single-byte accesses on a byte-wide data memory.
module data_mem_access_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk_in,
  input logic reset_in,
  data_mem_access_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              we_q;
  logic              sign_q;
  logic              err_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [7:0]        mwd_q;

  logic [1:0]        req_last;
  logic              req_err;
  logic [1:0]        cnt_nx;
  logic [DATA_W-1:0] asm_nx;
  logic [DATA_W-1:0] ld_val;

  assign cnt_nx = cnt + 2'd1;

  assign bus.busy_out     = (state != S_IDLE);
  assign bus.done_out     = (state == S_DONE);
  assign bus.err_out      = (state == S_DONE) & err_q;
  assign bus.rd_out       = rd_q;
  assign bus.mem_addr_out = maddr_q;
  assign bus.mem_wd_out   = mwd_q;
  assign bus.mem_we_out   = (state == S_ACCESS) & we_q;

  // Decode request size into last byte index and alignment error
  always_comb begin
    req_last = 2'd0;
    req_err  = 1'b0;
    unique case (1'b1)
      bus.size_in == 2'b00: req_last = 2'd0;
      bus.size_in == 2'b01: begin
        req_last = 2'd1;
        req_err  = bus.addr_in[0];
      end
      bus.size_in == 2'b10: begin
        req_last = 2'd3;
        req_err  = |bus.addr_in[1:0];
      end
      default: req_err = 1'b1;
    endcase
  end

  // Merge the byte being read this cycle into its lane
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{cnt, 3'b000} +: 8] = bus.mem_rd_in;
  end

  // Zero/sign extend the assembled value from bit 8N-1
  always_comb begin
    ld_val = asm_nx;
    unique case (last)
      2'd0: ld_val = {{(DATA_W-8){sign_q & asm_nx[7]}},
                      asm_nx[7:0]};
      2'd1: ld_val = {{(DATA_W-16){sign_q & asm_nx[15]}},
                      asm_nx[15:0]};
      default: ld_val = asm_nx;
    endcase
  end

  // Sequencer state, request latches and memory-side registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last    <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      asm_q   <= '0;
      rd_q    <= '0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_in) begin
            we_q   <= bus.we_in;
            sign_q <= bus.sign_in;
            wd_q   <= bus.wd_in;
            last   <= req_last;
            err_q  <= req_err;
            cnt    <= '0;
            asm_q  <= '0;
            if (req_err) begin
              state <= S_DONE;
            end else begin
              state   <= S_ACCESS;
              maddr_q <= bus.addr_in;
              mwd_q   <= bus.wd_in[7:0];
            end
          end
        end
        S_ACCESS: begin
          if (!we_q) asm_q <= asm_nx;
          if (cnt == last) begin
            state <= S_DONE;
            if (!we_q) rd_q <= ld_val;
          end else begin
            cnt     <= cnt_nx;
            maddr_q <= maddr_q + 1'b1;
            mwd_q   <= wd_q[{cnt_nx, 3'b000} +: 8];
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
